// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with bounds [MIN_VAL, MAX_VAL], variable step,
// parallel load and a runtime wrap-or-saturate mode. Boundary events are
// reported as registered one-cycle pulses plus registered level flags.
module updown_counter_param #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STEP_W    = 4,
  parameter logic [WIDTH-1:0] MIN_VAL   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = MIN_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              direction,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [STEP_W-1:0] step,
  input  logic              saturate,
  output logic [WIDTH-1:0]  counter_out,
  output logic              at_max,
  output logic              at_min,
  output logic              wrap_pulse,
  output logic              sat_pulse
);

  // Two guard bits: sums/differences of in-range values never overflow, and
  // the MSB of a difference acts as a "went negative" flag.
  localparam int unsigned EW = WIDTH + 2;

  localparam logic [EW-1:0] ONE_EXT   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] MIN_EXT   = {2'b00, MIN_VAL};
  localparam logic [EW-1:0] MAX_EXT   = {2'b00, MAX_VAL};
  localparam logic [EW-1:0] RANGE_EXT = MAX_EXT - MIN_EXT + ONE_EXT;

  localparam logic [63:0] STEP_MAX_64 = (64'd1 << STEP_W) - 64'd1;
  localparam logic [63:0] RANGE_64    = {{(64-WIDTH){1'b0}}, MAX_VAL}
                                      - {{(64-WIDTH){1'b0}}, MIN_VAL} + 64'd1;

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 2..32");
  end
  if (!(MIN_VAL < MAX_VAL)) begin : g_bad_bounds
    $error("updown_counter_param: MIN_VAL must be below MAX_VAL");
  end
  if (STEP_MAX_64 > RANGE_64) begin : g_bad_step
    $error("updown_counter_param: largest step exceeds the counting range");
  end
  if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_reset
    $error("updown_counter_param: RESET_VAL outside [MIN_VAL, MAX_VAL]");
  end

  logic [WIDTH-1:0] cnt_r;
  logic             at_max_r;
  logic             at_min_r;
  logic             wrap_r;
  logic             sat_r;

  logic [WIDTH-1:0] next_cnt_s;
  logic             next_wrap_s;
  logic             next_sat_s;

  logic [EW-1:0] cur_ext_s;
  logic [EW-1:0] step_ext_s;
  logic [EW-1:0] ld_ext_s;
  logic [EW-1:0] up_sum_s;
  logic [EW-1:0] up_wrap_s;
  logic [EW-1:0] dn_diff_s;
  logic [EW-1:0] dn_wrap_s;
  logic [EW-1:0] ld_below_s;
  logic [EW-1:0] ld_above_s;
  logic [EW-1:0] up_over_s;
  logic [EW-1:0] dn_under_s;

  assign cur_ext_s  = {2'b00, cnt_r};
  assign step_ext_s = {{(EW-STEP_W){1'b0}}, step};
  assign ld_ext_s   = {2'b00, load_value};

  assign up_sum_s  = cur_ext_s + step_ext_s;
  assign up_wrap_s = up_sum_s - RANGE_EXT;
  assign dn_diff_s = cur_ext_s - step_ext_s;
  assign dn_wrap_s = cur_ext_s + RANGE_EXT - step_ext_s;

  // MSB set on these differences means the left operand was the smaller one.
  assign ld_below_s = ld_ext_s - MIN_EXT;
  assign ld_above_s = MAX_EXT - ld_ext_s;
  assign up_over_s  = MAX_EXT - up_sum_s;
  assign dn_under_s = dn_diff_s - MIN_EXT;

  // Next-state selection: load beats count beats hold (reset is in the register).
  always_comb begin
    next_cnt_s  = cnt_r;
    next_wrap_s = 1'b0;
    next_sat_s  = 1'b0;
    if (load) begin
      if (ld_below_s[EW-1]) begin
        next_cnt_s = MIN_VAL;
        next_sat_s = 1'b1;
      end else if (ld_above_s[EW-1]) begin
        next_cnt_s = MAX_VAL;
        next_sat_s = 1'b1;
      end else begin
        next_cnt_s = load_value;
      end
    end else if (enable) begin
      if (direction) begin
        if (up_over_s[EW-1]) begin
          if (saturate) begin
            next_cnt_s = MAX_VAL;
            next_sat_s = 1'b1;
          end else begin
            next_cnt_s  = up_wrap_s[WIDTH-1:0];
            next_wrap_s = 1'b1;
          end
        end else begin
          next_cnt_s = up_sum_s[WIDTH-1:0];
        end
      end else begin
        if (dn_under_s[EW-1]) begin
          if (saturate) begin
            next_cnt_s = MIN_VAL;
            next_sat_s = 1'b1;
          end else begin
            next_cnt_s  = dn_wrap_s[WIDTH-1:0];
            next_wrap_s = 1'b1;
          end
        end else begin
          next_cnt_s = dn_diff_s[WIDTH-1:0];
        end
      end
    end else begin
      next_cnt_s = cnt_r;
    end
  end

  // State register with synchronous active-low reset; flags track the new value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r    <= RESET_VAL;
      at_max_r <= (RESET_VAL == MAX_VAL);
      at_min_r <= (RESET_VAL == MIN_VAL);
      wrap_r   <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      cnt_r    <= next_cnt_s;
      at_max_r <= (next_cnt_s == MAX_VAL);
      at_min_r <= (next_cnt_s == MIN_VAL);
      wrap_r   <= next_wrap_s;
      sat_r    <= next_sat_s;
    end
  end

  assign counter_out = cnt_r;
  assign at_max      = at_max_r;
  assign at_min      = at_min_r;
  assign wrap_pulse  = wrap_r;
  assign sat_pulse   = sat_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param: instance A uses default
// parameters, instance B uses bounds [10,20] with a 3-bit step.
module tb_updown_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals (defaults: 8-bit, 0..255, 4-bit step).
  logic       a_rst = 1'b0, a_en = 1'b0, a_dir = 1'b0, a_ld = 1'b0, a_sm = 1'b0;
  logic [7:0] a_lv = 8'd0;
  logic [3:0] a_step = 4'd0;
  logic [7:0] a_cnt;
  logic       a_max, a_min, a_wrap, a_sat;

  // Instance B signals (bounds 10..20, 3-bit step, reset 10).
  logic       b_rst = 1'b0, b_en = 1'b0, b_dir = 1'b0, b_ld = 1'b0, b_sm = 1'b0;
  logic [7:0] b_lv = 8'd0;
  logic [2:0] b_step = 3'd0;
  logic [7:0] b_cnt;
  logic       b_max, b_min, b_wrap, b_sat;

  updown_counter_param dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .direction(a_dir), .load(a_ld),
    .load_value(a_lv), .step(a_step), .saturate(a_sm), .counter_out(a_cnt),
    .at_max(a_max), .at_min(a_min), .wrap_pulse(a_wrap), .sat_pulse(a_sat)
  );

  updown_counter_param #(
    .WIDTH(8), .STEP_W(3), .MIN_VAL(8'd10), .MAX_VAL(8'd20), .RESET_VAL(8'd10)
  ) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .direction(b_dir), .load(b_ld),
    .load_value(b_lv), .step(b_step), .saturate(b_sm), .counter_out(b_cnt),
    .at_max(b_max), .at_min(b_min), .wrap_pulse(b_wrap), .sat_pulse(b_sat)
  );

  typedef struct {
    int unsigned dut;
    logic [7:0]  cnt;
    logic        amax;
    logic        amin;
    logic        wrap;
    logic        sat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Drive one cycle of stimulus on the selected instance and queue the
  // expected post-edge outputs.
  task automatic cyc(input int unsigned d, input logic r, input logic en,
                     input logic dir, input logic ld, input logic [7:0] lv,
                     input logic [3:0] st, input logic sm,
                     input logic [7:0] ec, input logic emax, input logic emin,
                     input logic ew, input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin
      a_rst = r; a_en = en; a_dir = dir; a_ld = ld; a_lv = lv; a_step = st; a_sm = sm;
    end else begin
      b_rst = r; b_en = en; b_dir = dir; b_ld = ld; b_lv = lv; b_step = st[2:0]; b_sm = sm;
    end
    e.dut = d; e.cnt = ec; e.amax = emax; e.amin = emin; e.wrap = ew; e.sat = es;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge presents a result; compare it against the queue head.
  initial begin
    exp_t       e;
    logic [11:0] act;
    logic [11:0] req;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) act = {a_cnt, a_max, a_min, a_wrap, a_sat};
        else            act = {b_cnt, b_max, b_min, b_wrap, b_sat};
        req = {e.cnt, e.amax, e.amin, e.wrap, e.sat};
        checks++;
        if (act !== req) begin
          failures++;
          $display("FAIL %s dut%0d: got cnt=%0d max=%b min=%b wrap=%b sat=%b, expected cnt=%0d max=%b min=%b wrap=%b sat=%b",
                   e.name, e.dut, act[11:4], act[3], act[2], act[1], act[0],
                   e.cnt, e.amax, e.amin, e.wrap, e.sat);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Instance A: reset, full up-count with wrap ----
    cyc(0, 0, 0, 0, 0, 8'd0, 4'd0, 0, 8'd0, 0, 1, 0, 0, "a_reset0");
    cyc(0, 0, 1, 1, 0, 8'd0, 4'd1, 0, 8'd0, 0, 1, 0, 0, "a_reset1");
    for (int i = 1; i <= 255; i++) begin
      cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 0, i[7:0], (i == 255), 0, 0, 0, "a_up");
    end
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 0, 8'd0, 0, 1, 1, 0, "a_wrap_top");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 0, 8'd1, 0, 0, 0, 0, "a_wrap_clear");

    // ---- Instance A: enable toggling ----
    cyc(0, 0, 1, 1, 0, 8'd0, 4'd1, 0, 8'd0, 0, 1, 0, 0, "a_reset2");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 0, 8'd1, 0, 0, 0, 0, "a_tog1");
    cyc(0, 1, 0, 1, 0, 8'd0, 4'd1, 0, 8'd1, 0, 0, 0, 0, "a_tog2");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 0, 8'd2, 0, 0, 0, 0, "a_tog3");
    cyc(0, 1, 0, 1, 0, 8'd0, 4'd1, 0, 8'd2, 0, 0, 0, 0, "a_tog4");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 0, 8'd3, 0, 0, 0, 0, "a_tog5");
    cyc(0, 1, 0, 1, 0, 8'd0, 4'd1, 0, 8'd3, 0, 0, 0, 0, "a_tog6");

    // ---- Instance A: down wrap below 0, saturate at top, step 0, load ----
    cyc(0, 1, 1, 0, 0, 8'd0, 4'd4, 0, 8'd255, 1, 0, 1, 0, "a_down_wrap");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 1, 8'd255, 1, 0, 0, 1, "a_sat_hold1");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd1, 1, 8'd255, 1, 0, 0, 1, "a_sat_hold2");
    cyc(0, 1, 1, 1, 0, 8'd0, 4'd0, 1, 8'd255, 1, 0, 0, 0, "a_step0");
    cyc(0, 1, 1, 0, 1, 8'd200, 4'd3, 0, 8'd200, 0, 0, 0, 0, "a_load");
    cyc(0, 1, 0, 0, 0, 8'd0, 4'd3, 0, 8'd200, 0, 0, 0, 0, "a_hold");

    // ---- Instance B: wrap mode, step 7 ----
    cyc(1, 0, 0, 1, 0, 8'd0, 4'd7, 0, 8'd10, 0, 1, 0, 0, "b_reset");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd7, 0, 8'd17, 0, 0, 0, 0, "b_up17");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd7, 0, 8'd13, 0, 0, 1, 0, "b_wrap13");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd7, 0, 8'd20, 1, 0, 0, 0, "b_up20");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd7, 0, 8'd16, 0, 0, 1, 0, "b_wrap16");
    cyc(1, 1, 1, 0, 0, 8'd0, 4'd7, 0, 8'd20, 1, 0, 1, 0, "b_dwrap20");
    cyc(1, 1, 1, 0, 0, 8'd0, 4'd7, 0, 8'd13, 0, 0, 0, 0, "b_down13");

    // ---- Instance B: saturate mode, step 4 ----
    cyc(1, 0, 1, 1, 0, 8'd0, 4'd4, 1, 8'd10, 0, 1, 0, 0, "b_reset2");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd4, 1, 8'd14, 0, 0, 0, 0, "b_up14");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd4, 1, 8'd18, 0, 0, 0, 0, "b_up18");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd4, 1, 8'd20, 1, 0, 0, 1, "b_sat20a");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd4, 1, 8'd20, 1, 0, 0, 1, "b_sat20b");
    cyc(1, 1, 1, 0, 0, 8'd0, 4'd4, 1, 8'd16, 0, 0, 0, 0, "b_dn16");
    cyc(1, 1, 1, 0, 0, 8'd0, 4'd4, 1, 8'd12, 0, 0, 0, 0, "b_dn12");
    cyc(1, 1, 1, 0, 0, 8'd0, 4'd4, 1, 8'd10, 0, 1, 0, 1, "b_sat10");

    // ---- Instance B: load clamping and priority ----
    cyc(1, 1, 1, 1, 1, 8'd5, 4'd4, 0, 8'd10, 0, 1, 0, 1, "b_load_lo");
    cyc(1, 1, 1, 1, 1, 8'd15, 4'd4, 0, 8'd15, 0, 0, 0, 0, "b_load15");
    cyc(1, 1, 1, 1, 1, 8'd12, 4'd4, 0, 8'd12, 0, 0, 0, 0, "b_load_wins");
    cyc(1, 1, 1, 1, 1, 8'd250, 4'd4, 0, 8'd20, 1, 0, 0, 1, "b_load_hi");
    cyc(1, 1, 1, 1, 1, 8'd12, 4'd4, 0, 8'd12, 0, 0, 0, 0, "b_load12");

    // ---- Instance B: reset overrides load and enable mid-count ----
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd5, 0, 8'd17, 0, 0, 0, 0, "b_up17b");
    cyc(1, 0, 1, 1, 1, 8'd15, 4'd5, 0, 8'd10, 0, 1, 0, 0, "b_rst_wins");
    cyc(1, 1, 1, 1, 0, 8'd0, 4'd1, 0, 8'd11, 0, 0, 0, 0, "b_resume");

    // Let the monitor drain the queue, bounded by a few cycles.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the team's 8-bit up/down counter. Adds configurable width, bounds [MIN_VAL, MAX_VAL], variable step, parallel load, and a runtime wrap-or-saturate mode. Boundary events are reported through registered one-cycle pulses and level flags. It is used as a general event/position counter in the exercise designs.

Parameters:
WIDTH, 8, counter width in bits (2..32)
STEP_W, 4, step input width; elaboration fails unless 2^STEP_W-1 <= MAX_VAL-MIN_VAL+1
MIN_VAL, 0, lower bound inclusive
MAX_VAL, 2^WIDTH-1, upper bound inclusive; elaboration fails unless MIN_VAL < MAX_VAL
RESET_VAL, MIN_VAL, value after reset; must lie in [MIN_VAL, MAX_VAL]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on rising clk)
enable  input  1  count enable
direction  input  1  1 = up, 0 = down
load  input  1  parallel load strobe
load_value  input  WIDTH  value to load
step  input  STEP_W  increment/decrement magnitude
saturate  input  1  1 = clamp at bounds, 0 = wrap within [MIN_VAL, MAX_VAL]
counter_out  output  WIDTH  registered count
at_max  output  1  counter_out == MAX_VAL (decode of register)
at_min  output  1  counter_out == MIN_VAL (decode of register)
wrap_pulse  output  1  registered; high one cycle after an update that wrapped
sat_pulse  output  1  registered; high one cycle after an update that was clamped

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Priority per rising clk edge: rst=0 > load=1 > enable=1 > hold.
- Reset: counter_out=RESET_VAL, wrap_pulse=0, sat_pulse=0. at_min/at_max follow the decode. Reset mid-count takes effect on the next edge and overrides load/enable.
- Load: counter_out <= load_value clamped to [MIN_VAL, MAX_VAL]. sat_pulse=1 if clamping occurred, else 0. wrap_pulse=0. Ignores enable, direction, step.
- Count (enable=1, load=0): next = counter_out ± step. Arithmetic is done at WIDTH+2 bits, so there is no native overflow. Let RANGE = MAX_VAL-MIN_VAL+1.
  - Up, cur+step <= MAX_VAL: next = cur+step.
  - Up, cur+step > MAX_VAL: saturate=1 gives next=MAX_VAL and sat_pulse=1; saturate=0 gives next=cur+step-RANGE and wrap_pulse=1.
  - Down, cur-step >= MIN_VAL: next = cur-step.
  - Down, cur-step < MIN_VAL: saturate=1 gives next=MIN_VAL and sat_pulse=1; saturate=0 gives next=cur-step+RANGE and wrap_pulse=1.
  - Saturate already at the bound with step>0: value holds and sat_pulse=1 on every such cycle.
  - step=0: value holds, no pulses.
- Hold (enable=0, load=0): value unchanged, wrap_pulse=0, sat_pulse=0.
- Pulses are registered with counter_out and are never high at the same time. They deassert on the next edge unless the next update re-triggers them.
- Latency: one clk from input sampling to counter_out and pulses. No combinational path from inputs to outputs.
- direction, step and saturate are sampled each edge; changing any of them mid-run has no side effects.

Test Plan:
- Defaults, rst=0 for 2 cycles, then rst=1, enable=1, direction=1, step=1, saturate=0 -> counter_out 0,1,2,...; at 255 the next value is 0 with wrap_pulse=1 for exactly one cycle; at_max=1 while at 255.
- enable toggled every cycle while counting up from 0 -> counter_out advances only on enabled edges (0,1,1,2,2,3...); no pulses.
- MIN_VAL=10, MAX_VAL=20, STEP_W=3, RESET_VAL=10, saturate=0, up, step=7 -> 10,17,13(wrap),20,16(wrap); then down step=7 -> 16,20(wrap).
- Same parameters, saturate=1, up, step=4 from 10 -> 14,18,20(sat_pulse),20(sat_pulse); then down step=4 -> 16,12,10(sat_pulse); at_min=1 at 10.
- load=1 with load_value=5 and enable=1 (MIN=10,MAX=20) -> counter_out=10, sat_pulse=1; load_value=15 -> 15, no pulse; load and enable together -> load wins.
- Counting up at 17 with load=1, rst=0 on the same edge -> counter_out=RESET_VAL (10), pulses 0; rst released -> counting resumes from 10 next edge.
